// File: rtl/ro_pkg.sv
// Shared constants and helpers for the readout frame collector.
package ro_pkg;

  localparam int unsigned NCH_DEF  = 8;
  localparam int unsigned TS_W_DEF = 16;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // Stored word layout: {timestamp, eve[NCH-1:0], pol[NCH-1:0]}.
  function automatic int unsigned frame_w(input int unsigned ts_w, input int unsigned nch);
    return ts_w + 2 * nch;
  endfunction

endpackage

// File: rtl/ro_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit.
module ro_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ro_frame_collector.sv
// Deserializes the time-multiplexed readout stream into timestamped event
// frames and buffers non-empty ones for the host side.
module ro_frame_collector
  import ro_pkg::*;
#(
  parameter int unsigned NCH        = NCH_DEF,
  parameter int unsigned TS_W       = TS_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned EMIT_EMPTY = 0
) (
  input  logic            clk_master,
  input  logic            rstb,
  input  logic            en,
  input  logic            frame_start,
  input  logic            in_mux_eve,
  input  logic            in_mux_pol_eve,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NCH-1:0]  out_eve,
  output logic [NCH-1:0]  out_pol,
  output logic [TS_W-1:0] out_ts,
  output logic            overflow,
  output logic [7:0]      drop_cnt,
  input  logic            clr_ovf
);

  localparam int unsigned W      = frame_w(TS_W, NCH);
  localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SLOT_W = $clog2(NCH + 1);
  localparam logic [SLOT_W-1:0] SLOT_DONE = SLOT_W'(NCH);

  logic [0:0]        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [NCH-1:0]    eve_q, eve_d;
  logic [NCH-1:0]    pol_q, pol_d;
  logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0]   frame_ts_q, frame_ts_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              start, frame_done, push_req, drop;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0]      fifo_rdata, head;

  assign start      = en & frame_start;
  assign frame_done = (state_q == ST_COLLECT) && (slot_q == SLOT_DONE);
  assign push_req   = frame_done && ((eve_q != '0) || (EMIT_EMPTY != 0));
  assign fifo_pop   = ~fifo_empty & out_ready;
  assign drop       = push_req & fifo_full & ~fifo_pop;
  assign fifo_push  = push_req & ~drop;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    eve_d      = eve_q;
    pol_d      = pol_q;
    frame_ts_d = frame_ts_q;
    ts_cnt_d   = en ? ts_cnt_q + TS_W'(1) : ts_cnt_q;

    // A completed frame is pushed on the same edge that may load slot 0 of
    // the next one, so a new start both aborts partials and chains frames.
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d    = ST_COLLECT;
        eve_d[0]   = in_mux_eve;
        pol_d[0]   = in_mux_eve & in_mux_pol_eve;
        frame_ts_d = ts_cnt_q;
        slot_d     = SLOT_W'(1);
      end
    end else if (!en && !frame_done) begin
      state_d = ST_IDLE;
      slot_d  = '0;
    end else if (start) begin
      eve_d[0]   = in_mux_eve;
      pol_d[0]   = in_mux_eve & in_mux_pol_eve;
      frame_ts_d = ts_cnt_q;
      slot_d     = SLOT_W'(1);
    end else if (frame_done) begin
      state_d = ST_IDLE;
      slot_d  = '0;
    end else begin
      eve_d[slot_q[IDX_W-1:0]] = in_mux_eve;
      pol_d[slot_q[IDX_W-1:0]] = in_mux_eve & in_mux_pol_eve;
      slot_d                   = slot_q + SLOT_W'(1);
    end
  end

  // Clear beats the counter, but a drop on the clearing edge keeps the flag.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      overflow_d = drop;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      eve_q      <= '0;
      pol_q      <= '0;
      ts_cnt_q   <= '0;
      frame_ts_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      eve_q      <= eve_d;
      pol_q      <= pol_d;
      ts_cnt_q   <= ts_cnt_d;
      frame_ts_q <= frame_ts_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ro_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_master),
    .rst_ni  (rstb),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({frame_ts_q, eve_q, pol_q}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head      = fifo_empty ? '0 : fifo_rdata;
  assign out_valid = ~fifo_empty;
  assign {out_ts, out_eve, out_pol} = head;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ro_frame_collector.sv
// Directed bench for ro_frame_collector; a second instance has EMIT_EMPTY=1.
module tb_ro_frame_collector;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        en = 1'b0;
  logic        frame_start = 1'b0;
  logic        in_eve = 1'b0;
  logic        in_pol = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_ovf = 1'b0;

  logic        out_valid, overflow;
  logic [7:0]  out_eve, out_pol, drop_cnt;
  logic [15:0] out_ts;
  logic        e_valid, e_overflow;
  logic [7:0]  e_eve, e_pol, e_drop_cnt;
  logic [15:0] e_ts;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ro_frame_collector #(.NCH(8), .TS_W(16), .FIFO_DEPTH(4), .EMIT_EMPTY(0)) dut (
    .clk_master(clk), .rstb(rstb), .en(en), .frame_start(frame_start),
    .in_mux_eve(in_eve), .in_mux_pol_eve(in_pol), .out_valid(out_valid),
    .out_ready(out_ready), .out_eve(out_eve), .out_pol(out_pol), .out_ts(out_ts),
    .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  ro_frame_collector #(.NCH(8), .TS_W(16), .FIFO_DEPTH(4), .EMIT_EMPTY(1)) dut_e (
    .clk_master(clk), .rstb(rstb), .en(en), .frame_start(frame_start),
    .in_mux_eve(in_eve), .in_mux_pol_eve(in_pol), .out_valid(e_valid),
    .out_ready(out_ready), .out_eve(e_eve), .out_pol(e_pol), .out_ts(e_ts),
    .overflow(e_overflow), .drop_cnt(e_drop_cnt), .clr_ovf(clr_ovf)
  );

  // Called just after a negedge; returns just after the negedge following slot 7.
  task automatic drive_frame(input logic [7:0] eve, input logic [7:0] pol);
    for (int k = 0; k < 8; k++) begin
      frame_start = (k == 0);
      in_eve      = eve[k];
      in_pol      = pol[k];
      @(negedge clk);
    end
    frame_start = 1'b0;
    in_eve      = 1'b0;
    in_pol      = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0; frame_start = 1'b0; in_eve = 1'b0; in_pol = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, out_eve, out_pol, out_ts, overflow, drop_cnt} !== 42'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {out_valid, out_eve, out_pol, out_ts, overflow, drop_cnt});
    end
    total++;
    if ({e_valid, e_eve, e_pol, e_ts, e_overflow, e_drop_cnt} !== 42'd0) begin
      bad++;
      $display("FAIL reset_outputs_emit got=%h exp=0",
               {e_valid, e_eve, e_pol, e_ts, e_overflow, e_drop_cnt});
    end
    rstb = 1'b1;
  endtask

  task automatic test_single_frame();
    do_reset();
    en = 1'b1;
    repeat (16) @(negedge clk);
    drive_frame(8'b1010_0001, 8'hFF);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_early_valid got=%b exp=0", out_valid);
    end
    @(negedge clk);
    total++;
    if ({out_valid, out_ts, out_eve, out_pol} !== {1'b1, 16'h0010, 8'hA1, 8'hA1}) begin
      bad++;
      $display("FAIL single_word got v=%b ts=%h eve=%h pol=%h exp v=1 ts=0010 eve=a1 pol=a1",
               out_valid, out_ts, out_eve, out_pol);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, out_ts, out_eve, out_pol} !== {1'b1, 16'h0010, 8'hA1, 8'hA1}) begin
      bad++;
      $display("FAIL single_hold got v=%b ts=%h eve=%h pol=%h", out_valid, out_ts, out_eve, out_pol);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({out_valid, out_eve} !== 9'd0) begin
      bad++; $display("FAIL single_pop got v=%b eve=%h exp v=0 eve=00", out_valid, out_eve);
    end
  endtask

  task automatic test_empty_frame();
    do_reset();
    en = 1'b1;
    drive_frame(8'h00, 8'hFF);
    @(negedge clk);
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, drop_cnt, overflow} !== 10'd0) begin
      bad++;
      $display("FAIL empty_dropped got v=%b cnt=%0d ovf=%b exp 0 0 0", out_valid, drop_cnt, overflow);
    end
    total++;
    if ({e_valid, e_ts, e_eve, e_pol} !== {1'b1, 16'h0000, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL empty_emitted got v=%b ts=%h eve=%h pol=%h exp v=1 ts=0000 eve=00 pol=00",
               e_valid, e_ts, e_eve, e_pol);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_eve [4];
    exp_eve = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    en = 1'b1;
    drive_frame(8'h11, 8'hFF);
    drive_frame(8'h22, 8'hFF);
    drive_frame(8'h33, 8'hFF);
    drive_frame(8'h44, 8'hFF);
    drive_frame(8'h55, 8'hFF);
    drive_frame(8'h66, 8'hFF);
    @(negedge clk);
    total++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd2}) begin
      bad++; $display("FAIL b2b_overflow got ovf=%b cnt=%0d exp ovf=1 cnt=2", overflow, drop_cnt);
    end
    // Another drop on the very edge clr_ovf is applied.
    drive_frame(8'h77, 8'hFF);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    total++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd0}) begin
      bad++; $display("FAIL clr_vs_drop got ovf=%b cnt=%0d exp ovf=1 cnt=0", overflow, drop_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_valid, out_ts, out_eve, out_pol} !== {1'b1, 16'(8 * i), exp_eve[i], exp_eve[i]}) begin
        bad++;
        $display("FAIL b2b_drain%0d got v=%b ts=%h eve=%h pol=%h exp v=1 ts=%h eve=%h",
                 i, out_valid, out_ts, out_eve, out_pol, 16'(8 * i), exp_eve[i]);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_empty got v=%b exp 0", out_valid);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    total++;
    if ({overflow, drop_cnt} !== 9'd0) begin
      bad++; $display("FAIL b2b_clear got ovf=%b cnt=%0d exp 0 0", overflow, drop_cnt);
    end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp_eve [4];
    exp_eve = '{8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    en = 1'b1;
    drive_frame(8'h11, 8'hFF);
    drive_frame(8'h22, 8'hFF);
    drive_frame(8'h33, 8'hFF);
    drive_frame(8'h44, 8'hFF);
    drive_frame(8'h55, 8'hFF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({overflow, drop_cnt} !== 9'd0) begin
      bad++; $display("FAIL fullpop_nodrop got ovf=%b cnt=%0d exp 0 0", overflow, drop_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_valid, out_ts, out_eve} !== {1'b1, 16'(8 * (i + 1)), exp_eve[i]}) begin
        bad++;
        $display("FAIL fullpop_drain%0d got v=%b ts=%h eve=%h exp v=1 ts=%h eve=%h",
                 i, out_valid, out_ts, out_eve, 16'(8 * (i + 1)), exp_eve[i]);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 264; i++) drive_frame(8'h01, 8'h01);
    @(negedge clk);
    total++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd255}) begin
      bad++; $display("FAIL drop_saturate got ovf=%b cnt=%0d exp ovf=1 cnt=255", overflow, drop_cnt);
    end
  endtask

  task automatic test_abort();
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      frame_start = (k == 0);
      in_eve = 1'b1;
      in_pol = 1'b1;
      @(negedge clk);
    end
    drive_frame(8'h3C, 8'h0F);
    @(negedge clk);
    total++;
    if ({out_valid, out_ts, out_eve, out_pol} !== {1'b1, 16'h0005, 8'h3C, 8'h0C}) begin
      bad++;
      $display("FAIL abort_word got v=%b ts=%h eve=%h pol=%h exp v=1 ts=0005 eve=3c pol=0c",
               out_valid, out_ts, out_eve, out_pol);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({out_valid, drop_cnt} !== 9'd0) begin
      bad++; $display("FAIL abort_single got v=%b cnt=%0d exp 0 0", out_valid, drop_cnt);
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      frame_start = (k == 0);
      in_eve = 1'b1;
      in_pol = 1'b1;
      @(negedge clk);
    end
    frame_start = 1'b0;
    en = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL endrop_nooutput got v=%b exp 0", out_valid);
    end
    en = 1'b1;
    drive_frame(8'h81, 8'h80);
    @(negedge clk);
    total++;
    if ({out_valid, out_ts, out_eve, out_pol} !== {1'b1, 16'h0003, 8'h81, 8'h80}) begin
      bad++;
      $display("FAIL endrop_next got v=%b ts=%h eve=%h pol=%h exp v=1 ts=0003 eve=81 pol=80",
               out_valid, out_ts, out_eve, out_pol);
    end
  endtask

  task automatic test_ts_wrap_and_reset();
    do_reset();
    en = 1'b1;
    repeat (65535) @(negedge clk);
    drive_frame(8'h01, 8'h01);
    drive_frame(8'h01, 8'h01);
    @(negedge clk);
    total++;
    if ({out_valid, out_ts, out_eve} !== {1'b1, 16'hFFFF, 8'h01}) begin
      bad++; $display("FAIL wrap_first got v=%b ts=%h eve=%h exp v=1 ts=ffff eve=01", out_valid, out_ts, out_eve);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({out_valid, out_ts, out_eve} !== {1'b1, 16'h0007, 8'h01}) begin
      bad++; $display("FAIL wrap_second got v=%b ts=%h eve=%h exp v=1 ts=0007 eve=01", out_valid, out_ts, out_eve);
    end
    for (int k = 0; k < 3; k++) begin
      frame_start = (k == 0);
      in_eve = 1'b1;
      @(negedge clk);
    end
    frame_start = 1'b0;
    #2 rstb = 1'b0;
    #1;
    total++;
    if ({out_valid, out_eve, out_pol, out_ts, overflow, drop_cnt} !== 42'd0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", {out_valid, out_eve, out_pol, out_ts, overflow, drop_cnt});
    end
    en = 1'b0;
    in_eve = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_fifo_empty got v=%b exp 0", out_valid);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_empty_frame();
    test_back_to_back();
    test_full_pop_push();
    test_saturate();
    test_abort();
    test_en_drop();
    test_ts_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
